// File: rtl/clk_div_pkg.sv
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared constants, helpers and channel state type for the
//                clk_div_bank divider bank.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  // Index width for a bank of n channels; a single-channel bank still gets 1 bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // High-phase length ceil(div/2); widened so the all-ones divisor cannot wrap.
  function automatic longint unsigned half_of(input longint unsigned div);
    return (div + 1) >> 1;
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
//  Module      : clk_div_chan
//  Description : One programmable divider channel: counter, divisor with a
//                pending-update slot, IDLE/RUN control and registered outputs.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wdiv_i,
  output logic             div_out_o,
  output logic             tick_o,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] c_DEF = DIV_W'(DEF_DIV);

  chan_state_e      st_q, st_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             div_out_q, div_out_d;
  logic             tick_q, tick_d;
  logic             w_last;

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    // A write landing in the same cycle as an apply point is visible to it.
    pend_d     = wr_i ? wdiv_i : pend_q;
    pend_vld_d = wr_i | pend_vld_q;
    w_last     = (cnt_q == (div_q - c_ONE));

    unique case (st_q)
      ST_IDLE: begin
        if (pend_vld_d) begin
          div_d      = pend_d;
          pend_vld_d = 1'b0;
        end
        if (en_i) begin
          st_d  = ST_RUN;
          cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (w_last || sync_i) begin
          cnt_d = '0;
          if (pend_vld_d) begin
            div_d      = pend_d;
            pend_vld_d = 1'b0;
          end
          // Stop requests only take effect on a completed period.
          if (w_last && !en_i) begin
            st_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + c_ONE;
        end
      end
      default: st_d = ST_IDLE;
    endcase

    div_out_d = (st_d == ST_RUN) && (64'(cnt_d) < half_of(64'(div_d)));
    tick_d    = (st_d == ST_RUN) && (cnt_d == (div_d - c_ONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= c_DEF;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      div_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      div_out_q  <= div_out_d;
      tick_q     <= tick_d;
    end
  end

  assign div_out_o = div_out_q;
  assign tick_o    = tick_q;
  assign busy_o    = (st_q == ST_RUN);

endmodule

`default_nettype wire

// File: rtl/clk_div_bank.sv
// ============================================================================
//  Module      : clk_div_bank
//  Description : Bank of NUM_CH runtime-programmable clock dividers with
//                validated divisor writes and a global phase sync.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int DIV_W    = 8,
  parameter  int DEF_DIV  = 2,
  localparam int CH_IDX_W = int'(ch_idx_w(NUM_CH))
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                sync_all,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic                cfg_err,
  output logic [NUM_CH-1:0]   div_out,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   busy
);

  localparam logic [CH_IDX_W:0] c_NUM_CH = (CH_IDX_W + 1)'(NUM_CH);

  logic w_div_bad;
  logic w_ch_bad;
  logic w_cfg_ok;
  logic cfg_err_q;

  // Extra index bit lets the range check work for non-power-of-two banks.
  assign w_div_bad = (32'(cfg_div) < MIN_DIV);
  assign w_ch_bad  = ({1'b0, cfg_ch} >= c_NUM_CH);
  assign w_cfg_ok  = cfg_we && !w_div_bad && !w_ch_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && (w_div_bad || w_ch_bad);
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_wr;
    assign w_wr = w_cfg_ok && (cfg_ch == CH_IDX_W'(i));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en_i      (ch_en[i]),
      .sync_i    (sync_all),
      .wr_i      (w_wr),
      .wdiv_i    (cfg_div),
      .div_out_o (div_out[i]),
      .tick_o    (tick[i]),
      .busy_o    (busy[i])
    );
  end

endmodule

`default_nettype wire
